// File: rtl/spi_flash_reader_pkg.sv
// Shared definitions for the SPI flash read sequencer: flash opcodes,
// address width and the 3-bit sequencer state encoding.
package spi_flash_reader_pkg;

    localparam int ADDR_W = 24;

    localparam logic [7:0] SPI_CMD_READ      = 8'h03;
    localparam logic [7:0] SPI_CMD_FAST_READ = 8'h0B;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_DUMMY = 3'd3,
        ST_DATA  = 3'd4,
        ST_FIN   = 3'd5,
        ST_GAP   = 3'd6,
        ST_DONE  = 3'd7
    } state_t;

    // States in which the bit engine is allowed to raise SCLK.
    function automatic logic is_shifting(input state_t s);
        return (s == ST_CMD) || (s == ST_ADDR) || (s == ST_DUMMY) || (s == ST_DATA);
    endfunction

endpackage

// File: rtl/spi_flash_reader_spi_bit_engine.sv
// SPI mode-0 bit engine: SCLK phase toggle, shared 8-bit MOSI/MISO shift
// register, bit counter and the stall gate that withholds the 8th rise of
// a byte while the consumer still holds the previous one.
module spi_flash_reader_spi_bit_engine (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_byte,
    input  logic       run,
    input  logic       hold,
    input  logic [7:0] tx_next,
    input  logic       miso,
    output logic       sclk,
    output logic       mosi,
    output logic       byte_end,
    output logic [7:0] rx_byte
);

    logic       sclk_reg;
    logic       mosi_reg;
    logic [7:0] shift_reg;
    logic [2:0] bit_cnt_reg;
    logic       rise;

    // A rise is allowed whenever SCLK is low, except the byte-completing
    // rise while the downstream register is still occupied.
    assign rise     = run && !sclk_reg && !((bit_cnt_reg == 3'd7) && hold);
    assign byte_end = rise && (bit_cnt_reg == 3'd7);
    assign rx_byte  = {shift_reg[6:0], miso};
    assign sclk     = sclk_reg;
    assign mosi     = mosi_reg;

    // SCLK toggling with MISO capture on the rise and MOSI update on the fall.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_reg    <= 1'b0;
            mosi_reg    <= 1'b0;
            shift_reg   <= 8'h00;
            bit_cnt_reg <= 3'd0;
        end else if (load) begin
            sclk_reg    <= 1'b0;
            shift_reg   <= load_byte;
            mosi_reg    <= load_byte[7];
            bit_cnt_reg <= 3'd0;
        end else if (sclk_reg) begin
            // Falls always complete, even after the sequencer stops raising.
            sclk_reg <= 1'b0;
            if (bit_cnt_reg == 3'd0) begin
                shift_reg <= tx_next;
                mosi_reg  <= tx_next[7];
            end else begin
                mosi_reg  <= shift_reg[7];
            end
        end else if (rise) begin
            sclk_reg    <= 1'b1;
            shift_reg   <= {shift_reg[6:0], miso};
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
        end
    end

endmodule

// File: rtl/spi_flash_reader.sv
// SPI flash read sequencer: READ (or FAST_READ) command, 24-bit address,
// then streams len bytes over a valid/ready port, stretching SCLK on stall.
// Build option: define SPI_FAST_READ_EN for opcode 0x0B plus 8 dummy bits.
module spi_flash_reader
    import spi_flash_reader_pkg::*;
#(
    parameter int LEN_W          = 8,
    parameter int CS_HIGH_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic [7:0]        data,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              spi_cs_n,
    output logic              spi_sclk,
    output logic              spi_mosi,
    input  logic              spi_miso
);

`ifdef SPI_FAST_READ_EN
    localparam logic [7:0] CMD_BYTE   = SPI_CMD_FAST_READ;
    localparam state_t     AFTER_ADDR = ST_DUMMY;
`else
    localparam logic [7:0] CMD_BYTE   = SPI_CMD_READ;
    localparam state_t     AFTER_ADDR = ST_DATA;
`endif

    localparam logic [3:0] GAP_LAST = 4'(CS_HIGH_CYCLES - 1);

    state_t             state_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic [LEN_W-1:0]   len_cnt_reg;
    logic [1:0]         hdr_idx_reg;
    logic [3:0]         gap_cnt_reg;
    logic               cs_n_reg;
    logic               busy_reg;
    logic               done_reg;
    logic               data_valid_reg;
    logic [7:0]         data_reg;

    logic               load;
    logic               run;
    logic               hold;
    logic [7:0]         tx_next;
    logic               sclk;
    logic               byte_end;
    logic [7:0]         rx_byte;
    logic [7:0]         addr_bytes [3];

    // Address bytes in transmit order, most significant first.
    for (genvar gi = 0; gi < 3; gi++) begin : g_addr_bytes
        assign addr_bytes[gi] = addr_reg[ADDR_W-1-8*gi -: 8];
    end

    assign load = (state_reg == ST_IDLE) && start && (len != '0);
    assign run  = is_shifting(state_reg);
    assign hold = (state_reg == ST_DATA) && data_valid_reg && !data_ready;

    // Byte shifted out after the current one completes; zeros once the
    // header is done (dummy bits and don't-care MOSI during data).
    always_comb begin
        tx_next = 8'h00;
        if (state_reg == ST_ADDR) begin
            tx_next = addr_bytes[hdr_idx_reg];
        end
    end

    spi_flash_reader_spi_bit_engine u_bit_engine (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_byte (CMD_BYTE),
        .run       (run),
        .hold      (hold),
        .tx_next   (tx_next),
        .miso      (spi_miso),
        .sclk      (sclk),
        .mosi      (spi_mosi),
        .byte_end  (byte_end),
        .rx_byte   (rx_byte)
    );

    // Transaction sequencer, byte counter and output data register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            addr_reg       <= '0;
            len_cnt_reg    <= '0;
            hdr_idx_reg    <= 2'd0;
            gap_cnt_reg    <= 4'd0;
            cs_n_reg       <= 1'b1;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            data_valid_reg <= 1'b0;
            data_reg       <= 8'h00;
        end else begin
            done_reg <= 1'b0;

            // A landing byte keeps valid high even on a handshake edge.
            if (byte_end && (state_reg == ST_DATA)) begin
                data_reg       <= rx_byte;
                data_valid_reg <= 1'b1;
            end else if (data_valid_reg && data_ready) begin
                data_valid_reg <= 1'b0;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        busy_reg    <= 1'b1;
                        addr_reg    <= addr;
                        len_cnt_reg <= len;
                        hdr_idx_reg <= 2'd0;
                        if (len == '0) begin
                            done_reg  <= 1'b1;
                            state_reg <= ST_DONE;
                        end else begin
                            cs_n_reg  <= 1'b0;
                            state_reg <= ST_CMD;
                        end
                    end
                end
                ST_CMD: begin
                    if (byte_end) state_reg <= ST_ADDR;
                end
                ST_ADDR: begin
                    if (byte_end) begin
                        if (hdr_idx_reg == 2'd2) state_reg <= AFTER_ADDR;
                        else hdr_idx_reg <= hdr_idx_reg + 2'd1;
                    end
                end
                ST_DUMMY: begin
                    if (byte_end) state_reg <= ST_DATA;
                end
                ST_DATA: begin
                    if (byte_end) begin
                        len_cnt_reg <= len_cnt_reg - LEN_W'(1);
                        if (len_cnt_reg == LEN_W'(1)) state_reg <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    // Let the last SCLK high phase finish before releasing CS.
                    if (!sclk) begin
                        cs_n_reg    <= 1'b1;
                        gap_cnt_reg <= 4'd0;
                        state_reg   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_reg == GAP_LAST) begin
                        done_reg  <= 1'b1;
                        state_reg <= ST_DONE;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + 4'd1;
                    end
                end
                ST_DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign busy       = busy_reg;
    assign done       = done_reg;
    assign data       = data_reg;
    assign data_valid = data_valid_reg;
    assign spi_cs_n   = cs_n_reg;
    assign spi_sclk   = sclk;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Self-checking bench for spi_flash_reader with a behavioural SPI flash.
// Honours SPI_FAST_READ_EN in the same way as the design.
module tb_spi_flash_reader;

    localparam int LEN_W = 8;
    localparam int CSH   = 4;
`ifdef SPI_FAST_READ_EN
    localparam int         HDR_BITS  = 40;
    localparam logic [7:0] CMD       = 8'h0B;
    localparam int         FIRST_LAT = 95;
`else
    localparam int         HDR_BITS  = 32;
    localparam logic [7:0] CMD       = 8'h03;
    localparam int         FIRST_LAT = 79;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [23:0]      addr;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             done;
    logic [7:0]       data;
    logic             data_valid;
    logic             data_ready;
    logic             spi_cs_n;
    logic             spi_sclk;
    logic             spi_mosi;
    logic             spi_miso;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int txn_id = 0;

    // Flash model state
    logic [7:0]  flash_q [$];
    logic [39:0] hdr_word;
    logic        prev_sclk = 1'b0;
    int          rises = 0;
    int          rise_total = 0;
    int          mosi_ones = 0;

    spi_flash_reader #(.LEN_W(LEN_W), .CS_HIGH_CYCLES(CSH)) dut (
        .clk(clk), .reset(reset), .start(start), .addr(addr), .len(len),
        .busy(busy), .done(done), .data(data), .data_valid(data_valid),
        .data_ready(data_ready), .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s (txn %0d): observed %0h, expected %0h", tag, txn_id, obs, exp);
        end
    endtask

    // One clock; then, away from the edge, run the flash side of the bus.
    task automatic step();
        int j;
        int b;
        @(posedge clk);
        @(negedge clk);
        if (spi_cs_n) begin
            rises    = 0;
            spi_miso = 1'b0;
        end else if (spi_sclk && !prev_sclk) begin
            if (rises < HDR_BITS) hdr_word = {hdr_word[38:0], spi_mosi};
            else if (spi_mosi) mosi_ones++;
            rises++;
            rise_total++;
        end else if (!spi_sclk && prev_sclk && rises >= HDR_BITS) begin
            j = rises - HDR_BITS;
            b = j / 8;
            spi_miso = (b < flash_q.size()) ? flash_q[b][7 - (j % 8)] : 1'b0;
        end
        prev_sclk = spi_sclk;
    endtask

    // mode 0: ready always high; 1: ready low 30 cycles after byte 0; 2: random ready
    task automatic do_txn(input logic [23:0] a, input int n, input int mode);
        int e, land_n, last_land, cs_rise, done_cyc, done_cnt;
        int stall_left, snap, snap_total, busy_bad;
        bit pend, prev_valid, prev_cs, consumed, finished;
        logic [39:0] hw;
        txn_id++;
        hdr_word = '0; mosi_ones = 0; snap_total = rise_total;
        land_n = 0; last_land = 0; cs_rise = -1000; done_cyc = 0; done_cnt = 0;
        stall_left = 0; snap = 0; busy_bad = 0; pend = 0; finished = 0;
        addr = a; len = LEN_W'(n); start = 1'b1; data_ready = 1'b1;
        step();
        e = cyc;
        start = 1'b0;
        check("busy_after_accept", 32'(busy), 32'(1));
        for (int it = 0; it < 600; it++) begin
            if (mode == 1 && stall_left > 0) begin
                data_ready = 1'b0;
                stall_left--;
                if (stall_left == 0) pend = 1;
            end else if (mode == 2) begin
                data_ready = ($urandom_range(0, 2) != 0);
            end else begin
                data_ready = 1'b1;
            end
            consumed   = data_valid && data_ready;
            start      = busy ? 1'($urandom_range(0, 1)) : 1'b0;
            addr       = 24'($urandom);
            len        = LEN_W'($urandom);
            prev_valid = data_valid;
            prev_cs    = spi_cs_n;
            step();
            if (data_valid && (!prev_valid || consumed)) begin
                check("byte_value", 32'(data), 32'(flash_q[land_n]));
                if (land_n == 0) check("first_latency", cyc - e, FIRST_LAT);
                else if (mode == 0) check("byte_latency", cyc - e, FIRST_LAT + 16 * land_n);
                if (mode == 1 && land_n == 0) begin
                    stall_left = 30;
                    snap = rise_total;
                end
                land_n++;
                last_land = cyc;
            end
            if (pend) begin
                pend = 0;
                check("stall_rises", rise_total - snap, 7);
                check("stall_sclk_low", 32'(spi_sclk), 32'(0));
                check("stall_cs_low", 32'(spi_cs_n), 32'(0));
            end
            if (spi_cs_n && !prev_cs) cs_rise = cyc;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (done_cnt == 0 || done) begin
                if (!busy) busy_bad++;
            end else if (busy) begin
                busy_bad++;
            end
            if (done_cnt > 0 && !done && !data_valid) begin
                finished = 1;
                break;
            end
        end
        start = 1'b0;
        data_ready = 1'b1;
        hw = hdr_word >> (HDR_BITS - 32);
        check("finished", 32'(finished), 32'(1));
        check("byte_count", land_n, n);
        check("done_pulses", done_cnt, 1);
        check("cs_to_done", done_cyc - cs_rise, CSH);
        check("cs_after_last", 32'(((cs_rise - last_land) >= 1) && ((cs_rise - last_land) <= 2)), 32'(1));
        check("busy_window", busy_bad, 0);
        check("header", hw[31:0], {CMD, a});
`ifdef SPI_FAST_READ_EN
        check("dummy_bits", 32'(hdr_word[7:0]), 32'(0));
`endif
        check("mosi_data_zero", mosi_ones, 0);
        check("sclk_rises", rise_total - snap_total, HDR_BITS + 8 * n);
        check("end_pins", 32'({spi_cs_n, spi_sclk, busy}), 32'(3'b100));
        $display("txn %0d addr=%06h len=%0d mode=%0d bytes=%0d", txn_id, a, n, mode, land_n);
    endtask

    initial begin
        int idle_bad;
        int n;
        logic [23:0] a;
        reset = 1'b1; start = 1'b0; data_ready = 1'b1;
        addr = '0; len = '0; spi_miso = 1'b0;
        repeat (3) step();
        check("reset_pins", 32'({spi_cs_n, spi_sclk, spi_mosi}), 32'(3'b100));
        check("reset_status", 32'({busy, done, data_valid}), 32'(0));
        check("reset_data", 32'(data), 32'(0));
        reset = 1'b0;
        idle_bad = 0;
        repeat (20) begin
            step();
            if ({spi_cs_n, spi_sclk, spi_mosi, busy, data_valid, done} !== 6'b100000) idle_bad++;
        end
        check("idle_20", idle_bad, 0);
        $display("txn %0d idle after reset, violations=%0d", txn_id, idle_bad);

        // Directed read, consumer always ready
        flash_q = '{8'hA5, 8'h3C};
        do_txn(24'h012345, 2, 0);
        repeat (3) step();

        // Same read with a 30-cycle consumer stall after the first byte
        do_txn(24'h012345, 2, 1);
        repeat (3) step();

        // Zero-length request: no CS activity, one-cycle done
        txn_id++;
        addr = 24'h00ABCD; len = '0; start = 1'b1;
        step();
        start = 1'b0;
        check("len0_done", 32'(done), 32'(1));
        check("len0_busy", 32'(busy), 32'(1));
        check("len0_cs", 32'(spi_cs_n), 32'(1));
        step();
        check("len0_done_gone", 32'({done, busy}), 32'(0));
        idle_bad = 0;
        repeat (5) begin
            step();
            if (spi_cs_n !== 1'b1 || spi_sclk !== 1'b0) idle_bad++;
        end
        check("len0_cs_idle", idle_bad, 0);
        $display("txn %0d len=0 request", txn_id);

        // Reset in the middle of the address phase
        txn_id++;
        flash_q = '{8'h11, 8'h22, 8'h33};
        addr = 24'hFEDCBA; len = LEN_W'(3); start = 1'b1;
        step();
        start = 1'b0;
        repeat (29) step();
        reset = 1'b1;
        step();
        check("abort_pins", 32'({spi_cs_n, spi_sclk, spi_mosi}), 32'(3'b100));
        check("abort_status", 32'({busy, done, data_valid}), 32'(0));
        reset = 1'b0;
        step();
        $display("txn %0d reset at accept+30", txn_id);

        // Short read used for the fast-read timing as well
        flash_q = '{8'h5A};
        do_txn(24'h000010, 1, 0);
        repeat (2) step();

        // Randomised reads with random consumer back-pressure
        for (int t = 0; t < 5; t++) begin
            a = 24'($urandom);
            n = $urandom_range(1, 4);
            flash_q.delete();
            for (int i = 0; i < n; i++) flash_q.push_back(8'($urandom));
            do_txn(a, n, 2);
            repeat ($urandom_range(1, 4)) step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_flash_reader.md
Name: spi_flash_reader

Overview:
- Sequencer for the external SPI flash ROM (CS_n/SCLK/MOSI/MISO) used by the VGA SPI ROM design.
- Accepts a read request (24-bit address, byte count) and issues a standard READ command (0x03) plus address, MSB first.
- Streams returned bytes to the pixel pipeline over a valid/ready handshake, stretching SCLK when the consumer stalls.
- Sits between the pixel-clock video logic and the flash pins; one outstanding transaction at a time.

Parameters:
- LEN_W, 8, width of the byte-count input (max transaction = 2^LEN_W-1 bytes).
- CS_HIGH_CYCLES, 4, minimum clk cycles CS_n stays high between transactions (1..15).

Ports:
- clk  in  1  pixel clock; SCLK = clk/2.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request strobe; sampled only when busy=0.
- addr  in  24  flash byte address, captured on accepted start.
- len  in  LEN_W  byte count, captured on accepted start.
- busy  out  1  high from the cycle after accept until the done cycle inclusive.
- done  out  1  one-cycle pulse at transaction end.
- data  out  8  received byte, first bit received = data[7].
- data_valid  out  1  data holds an unconsumed byte.
- data_ready  in  1  consumer accepts data when data_valid & data_ready.
- spi_cs_n  out  1  flash chip select, active low.
- spi_sclk  out  1  SPI clock, mode 0, idles low.
- spi_mosi  out  1  command/address to flash.
- spi_miso  in  1  data from flash.

Behaviour:
- Reset values: spi_cs_n=1, spi_sclk=0, spi_mosi=0, busy=0, done=0, data_valid=0, data=0; state IDLE, all counters 0. Reset mid-transaction aborts immediately; the next cycle shows reset values.
- All outputs registered.
- States: IDLE -> CMD (8 bits) -> ADDR (24 bits) -> [DUMMY (8 bits), optional] -> DATA (8*len bits) -> GAP (CS high, CS_HIGH_CYCLES cycles) -> IDLE.
- Accept: start=1 in IDLE with len!=0 -> next cycle cs_n=0, sclk=0, mosi=cmd[7], busy=1.
- start with len=0: CS_n is never asserted; done pulses next cycle; busy=1 for that one cycle only.
- start while busy is ignored; addr and len are captured only on accept.
- Bit timing, two clk per bit:
  - Phase L: sclk=0, mosi stable.
  - Edge L->H: sclk<=1 and spi_miso is sampled into the shift register on the same edge.
  - Edge H->L: sclk<=0 and mosi<=next bit.
- Start accepted at edge E: the first SCLK rise is at edge E+1, the k-th bit's rise at edge E+1+2k.
- mosi is don't-care during DATA; it is driven 0.
- Byte completion: on the 8th DATA rise, data<=shift byte and data_valid<=1 (first byte at edge E+79).
- data_valid clears on the handshake edge unless a new byte lands on that same edge, in which case it stays 1 with the new data.
- Stall: if data_valid=1 & data_ready=0 when the 8th bit of the next byte is due, the L->H edge is withheld. sclk stays 0, cs_n stays 0, and the bit resumes the cycle after the handshake. No byte is ever overwritten or dropped.
- End: after the final byte is loaded, the FSM waits for sclk low, then sets cs_n<=1 and enters GAP. After CS_HIGH_CYCLES cycles it pulses done and drops busy on the same cycle. data_valid may still be 1 at done; the last byte remains until consumed.
- Byte counter is LEN_W bits and decrements per byte with no wrap. Address is sent verbatim; flash-side wrap at 2^24 is the flash's concern.

Optional Feature:
- SPI_FAST_READ_EN.
- Defined: command 0x0B, and DUMMY sends 8 zero bits (16 clk) between ADDR and DATA; first data_valid at edge E+95. Allows faster SCLK on slower flash parts.
- Undefined: command 0x03, no DUMMY state; timing as above.

Decomposition:
- Shared header alongside existing helpers defines: SPI_CMD_READ 8'h03, SPI_CMD_FAST_READ 8'h0B, state encodings (3-bit), ADDR_W 24.
- One natural sub-module: spi_bit_engine, holding the SCLK phase toggle, the 8-bit MOSI/MISO shift register, the bit counter and the stall gate. The FSM and byte counter stay in spi_flash_reader.

Test Plan:
- Reset, then idle 20 cycles -> cs_n=1, sclk=0, mosi=0, busy=0, data_valid=0 throughout.
- start, addr=0x012345, len=2, data_ready=1; flash model returns 0xA5, 0x3C -> MOSI bits 0x03,0x01,0x23,0x45; data=0xA5 valid at E+79, data=0x3C at E+95; cs_n high after the last bit; done pulses CS_HIGH_CYCLES later.
- Same transaction with data_ready=0 for 30 cycles after the first byte -> sclk held low before the 8th bit of byte 2; no rise during the stall; bytes still 0xA5, 0x3C; CS stays low.
- start with len=0 -> cs_n stays 1; done=1 for exactly one cycle, next cycle after start.
- reset asserted mid-ADDR (edge E+30) -> next cycle cs_n=1, sclk=0, busy=0; a new start then runs cleanly.
- SPI_FAST_READ_EN defined, addr=0x000010, len=1 -> MOSI 0x0B,0x00,0x00,0x10, then 8 zero bits; data valid at E+95; extra start pulses while busy are ignored.
